// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch run-control slice.
package stopwatch_pkg;

  localparam int DIGITS_DEF = 4;
  localparam logic [3:0] BCD_NINE = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_LAP   = 3'd3,
    ST_FULL  = 3'd4
  } swState_e;

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioning: synchronizer, press debounce and one-shot press event.
module btn_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 50000,
  parameter int DEB_W       = 16
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iBtn,
  output logic oEvent
);

  logic [SYNC_STAGES-1:0] syncR;
  logic [DEB_W-1:0]       debCntR;
  logic                   levelR;
  logic                   eventR;
  logic                   syncedS;
  logic                   levelSetS;

  assign syncedS   = syncR[SYNC_STAGES-1];
  assign levelSetS = syncedS & ~levelR & (debCntR == DEB_W'(DEB_CYCLES - 1));
  assign oEvent    = eventR;

  // Synchronizer shift, debounce counter, accepted level and its rising-edge event.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      syncR   <= '0;
      debCntR <= '0;
      levelR  <= 1'b0;
      eventR  <= 1'b0;
    end else begin
      syncR  <= {syncR[SYNC_STAGES-2:0], iBtn};
      // The level only ever rises through levelSetS, so this is its registered rising edge.
      eventR <= levelSetS;
      if (!syncedS) begin
        debCntR <= '0;
        levelR  <= 1'b0;
      end else if (levelSetS) begin
        levelR <= 1'b1;
      end else if (!levelR) begin
        debCntR <= debCntR + DEB_W'(1);
      end else begin
        debCntR <= debCntR;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control: button events, run/pause/lap/full sequencing, tick gating
// and live/lap display selection for a saturating BCD counter chain.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIGITS      = DIGITS_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 50000,
  parameter int DEB_W       = 16
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iStartStop,
  input  logic                  iLap,
  input  logic                  iClear,
  input  logic                  iTick,
  input  logic [4*DIGITS-1:0]   iCount,
  output logic                  oTickEn,
  output logic                  oCntClr,
  output logic [4*DIGITS-1:0]   oDisp,
  output logic [2:0]            oState,
  output logic                  oFull
);

  swState_e              stateR;
  logic [4*DIGITS-1:0]   lapR;
  logic                  cntClrR;
  logic                  fullR;
  logic                  evClearS, evStartStopS, evLapS;
  logic                  clrEvS, ssEvS, lapEvS;
  logic                  allNinesS, countingS, fullHitS;

  btn_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W))
    uBtnClear (.iClk(iClk), .iRst(iRst), .iBtn(iClear), .oEvent(evClearS));
  btn_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W))
    uBtnStartStop (.iClk(iClk), .iRst(iRst), .iBtn(iStartStop), .oEvent(evStartStopS));
  btn_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W))
    uBtnLap (.iClk(iClk), .iRst(iRst), .iBtn(iLap), .oEvent(evLapS));

  // Saturation detect: every digit of the live count at nine.
  always_comb begin
    allNinesS = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (iCount[4*d +: 4] != BCD_NINE) begin
        allNinesS = 1'b0;
      end else begin
        allNinesS = allNinesS;
      end
    end
  end

  assign clrEvS    = evClearS;
  assign ssEvS     = evStartStopS & ~evClearS;
  assign lapEvS    = evLapS & ~evClearS & ~evStartStopS;
  assign countingS = (stateR == ST_RUN) | (stateR == ST_LAP);
  assign fullHitS  = iTick & allNinesS;

  assign oTickEn = iTick & countingS & ~allNinesS;
  assign oDisp   = (stateR == ST_LAP) ? lapR : iCount;
  assign oState  = stateR;
  assign oCntClr = cntClrR;
  assign oFull   = fullR;

  // Run-control FSM with lap capture and registered clear/full outputs.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      stateR  <= ST_IDLE;
      lapR    <= '0;
      cntClrR <= 1'b0;
      fullR   <= 1'b0;
    end else begin
      cntClrR <= 1'b0;
      if (clrEvS) begin
        stateR  <= ST_IDLE;
        cntClrR <= 1'b1;
        fullR   <= 1'b0;
      end else begin
        case (stateR)
          ST_IDLE: if (ssEvS) stateR <= ST_RUN;
          ST_PAUSE: if (ssEvS) stateR <= ST_RUN;
          ST_RUN: begin
            if (ssEvS) begin
              stateR <= ST_PAUSE;
            end else if (lapEvS) begin
              stateR <= ST_LAP;
              lapR   <= iCount;
            end else if (fullHitS) begin
              stateR <= ST_FULL;
              fullR  <= 1'b1;
            end
          end
          ST_LAP: begin
            if (ssEvS) begin
              stateR <= ST_PAUSE;
            end else if (lapEvS) begin
              stateR <= ST_RUN;
            end else if (fullHitS) begin
              stateR <= ST_FULL;
              fullR  <= 1'b1;
            end
          end
          ST_FULL: stateR <= ST_FULL;
          default: begin
            stateR <= ST_IDLE;
            fullR  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized bench for stopwatch_ctrl against a cycle-level behavioural model
// that also plays the role of the BCD counter chain.
module tb_stopwatch_ctrl;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic        iClk = 1'b0;
  logic        iRst, iStartStop, iLap, iClear, iTick;
  logic [15:0] iCount;
  logic        oTickEn, oCntClr, oFull;
  logic [15:0] oDisp;
  logic [2:0]  oState;

  stopwatch_ctrl #(.DIGITS(4), .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB), .DEB_W(8)) dut (
    .iClk(iClk), .iRst(iRst), .iStartStop(iStartStop), .iLap(iLap), .iClear(iClear),
    .iTick(iTick), .iCount(iCount), .oTickEn(oTickEn), .oCntClr(oCntClr),
    .oDisp(oDisp), .oState(oState), .oFull(oFull)
  );

  always #5 iClk = ~iClk;

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: 0=IDLE 1=RUN 2=PAUSE 3=LAP 4=FULL; buttons indexed 0=clear 1=start/stop 2=lap.
  int          mState, mCount, cycNum, tickMode;
  logic [15:0] mLap;
  bit          mCntClr, mFull;
  bit          mSync [3][SYNC];
  int          mRun  [3];
  bit          mPend [3];

  function automatic logic [15:0] toBcd(input int v);
    logic [15:0] r;
    int t;
    r = 16'h0;
    t = v;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic resetModel();
    mState = 0; mCount = 0; mLap = 16'h0; mCntClr = 1'b0; mFull = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mRun[b] = 0; mPend[b] = 1'b0;
      for (int s = 0; s < SYNC; s++) mSync[b][s] = 1'b0;
    end
  endtask

  task automatic modelEdge();
    bit nines, active, tEn, raw [3];
    int oldCount;
    if (!iRst) begin
      resetModel();
      return;
    end
    oldCount = mCount;
    nines  = (mCount == 9999);
    active = (mState == 1) || (mState == 3);
    tEn    = iTick && active && !nines;
    if (mCntClr) mCount = 0;
    else if (tEn) mCount = mCount + 1;
    mCntClr = 1'b0;
    if (mPend[0]) begin
      mState = 0; mCntClr = 1'b1;
    end else if (mPend[1]) begin
      if (mState == 0 || mState == 2) mState = 1;
      else if (mState == 1 || mState == 3) mState = 2;
    end else if (mPend[2]) begin
      if (mState == 1) begin mState = 3; mLap = toBcd(oldCount); end
      else if (mState == 3) mState = 1;
    end else if (iTick && nines && active) begin
      mState = 4;
    end
    mFull = (mState == 4);
    raw[0] = iClear; raw[1] = iStartStop; raw[2] = iLap;
    // A press is accepted once the synchronized button has been high DEB samples in a row.
    for (int b = 0; b < 3; b++) begin
      if (mSync[b][SYNC-1]) mRun[b] = mRun[b] + 1;
      else mRun[b] = 0;
      mPend[b] = (mRun[b] == DEB);
      for (int s = SYNC - 1; s > 0; s--) mSync[b][s] = mSync[b][s-1];
      mSync[b][0] = raw[b];
    end
  endtask

  task automatic checkAll();
    bit active;
    active = (mState == 1) || (mState == 3);
    checkVal("state", {29'd0, oState}, mState);
    checkVal("full", {31'd0, oFull}, {31'd0, mFull});
    checkVal("cntClr", {31'd0, oCntClr}, {31'd0, mCntClr});
    checkVal("tickEn", {31'd0, oTickEn}, {31'd0, (iTick && active && mCount != 9999)});
    checkVal("disp", {16'd0, oDisp}, {16'd0, (mState == 3) ? mLap : toBcd(mCount)});
  endtask

  task automatic cycle();
    @(posedge iClk);
    modelEdge();
    #1;
    cycNum++;
    if (tickMode == 0) iTick = (cycNum % 10 == 0);
    else if (tickMode == 1) iTick = ($urandom_range(0, 3) == 0);
    else iTick = 1'b0;
    iCount = toBcd(mCount);
    @(negedge iClk);
    checkAll();
  endtask

  task automatic setCount(input int v);
    mCount = v;
    iCount = toBcd(v);
  endtask

  task automatic press(input int which, input int len, input int gap);
    if (which == 0) iClear = 1'b1;
    else if (which == 1) iStartStop = 1'b1;
    else iLap = 1'b1;
    repeat (len) cycle();
    iClear = 1'b0; iStartStop = 1'b0; iLap = 1'b0;
    repeat (gap) cycle();
  endtask

  initial begin
    int n;
    bit sawRun;
    resetModel();
    cycNum = 0; tickMode = 0;
    iRst = 1'b0; iStartStop = 1'b0; iLap = 1'b0; iClear = 1'b0;
    iTick = 1'b1; iCount = 16'h0;
    #3;
    checkVal("rstState", {29'd0, oState}, 32'd0);
    checkVal("rstTickEn", {31'd0, oTickEn}, 32'd0);
    checkVal("rstCntClr", {31'd0, oCntClr}, 32'd0);
    checkVal("rstFull", {31'd0, oFull}, 32'd0);
    repeat (3) cycle();
    iRst = 1'b1;

    // Short glitch is rejected.
    iStartStop = 1'b1;
    repeat (3) cycle();
    iStartStop = 1'b0;
    repeat (10) cycle();
    checkVal("glitchState", {29'd0, oState}, 32'd0);

    // Start latency: accepted on edge SYNC+DEB+1 after first high sample.
    iStartStop = 1'b1;
    repeat (SYNC + DEB) cycle();
    checkVal("startEarly", {29'd0, oState}, 32'd0);
    cycle();
    checkVal("startLat", {29'd0, oState}, 32'd1);
    repeat (13) cycle();
    iStartStop = 1'b0;
    repeat (20) cycle();

    // Lap freeze at 0123 while live count moves on.
    tickMode = 2;
    setCount(123);
    press(2, 8, 4);
    checkVal("lapState", {29'd0, oState}, 32'd3);
    tickMode = 0;
    n = 0;
    while (mCount < 125 && n < 60) begin cycle(); n++; end
    checkVal("lapAdvance", {31'd0, (mCount >= 125)}, 32'd1);
    checkVal("lapHold", {16'd0, oDisp}, 32'h0123);
    press(2, 8, 4);
    checkVal("lapRelease", {29'd0, oState}, 32'd1);

    // Saturation at 9999, then clear.
    setCount(9999);
    repeat (12) cycle();
    checkVal("fullState", {29'd0, oState}, 32'd4);
    checkVal("fullFlag", {31'd0, oFull}, 32'd1);
    repeat (20) cycle();
    iClear = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (oCntClr) n++;
      if (i == 8) iClear = 1'b0;
    end
    checkVal("clrPulses", n, 32'd1);
    checkVal("clrState", {29'd0, oState}, 32'd0);

    // Clear beats start/stop when both are accepted together in PAUSE.
    press(1, 8, 4);
    press(1, 8, 4);
    checkVal("pauseState", {29'd0, oState}, 32'd2);
    iStartStop = 1'b1; iClear = 1'b1;
    n = 0; sawRun = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (oCntClr) n++;
      if (oState == 3'd1) sawRun = 1'b1;
      if (i == 8) begin iStartStop = 1'b0; iClear = 1'b0; end
    end
    checkVal("dualClr", n, 32'd1);
    checkVal("dualNoRun", {31'd0, sawRun}, 32'd0);
    checkVal("dualState", {29'd0, oState}, 32'd0);

    // Random button traffic with random ticks and occasional near-full counts.
    tickMode = 1;
    for (int it = 0; it < 300; it++) begin
      int b;
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 2));
      if ($urandom_range(0, 19) == 0) setCount(int'($urandom_range(9995, 9999)));
      press(b, int'($urandom_range(1, 10)), int'($urandom_range(1, 6)));
    end

    // Asynchronous reset in LAP while a tick is present.
    tickMode = 2;
    press(0, 8, 4);
    press(1, 8, 4);
    press(2, 8, 4);
    checkVal("preRstLap", {29'd0, oState}, 32'd3);
    iTick = 1'b1;
    #1;
    checkVal("preRstTickEn", {31'd0, oTickEn}, {31'd0, (mCount != 9999)});
    iRst = 1'b0;
    #1;
    checkVal("asyncState", {29'd0, oState}, 32'd0);
    checkVal("asyncTickEn", {31'd0, oTickEn}, 32'd0);
    checkVal("asyncCntClr", {31'd0, oCntClr}, 32'd0);
    checkVal("asyncDisp", {16'd0, oDisp}, {16'd0, iCount});
    resetModel();
    iTick = 1'b0;
    repeat (3) cycle();
    iRst = 1'b1;
    tickMode = 0;
    repeat (20) cycle();
    checkVal("postRstIdle", {29'd0, oState}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Run-control sequencer for the 4-digit BCD up-counter chain (divider -> units/tens/hundreds/thousands -> 7-segment decoders). It conditions three push buttons (start/stop, lap, clear) and gates the divider tick into the units counter. It also issues a synchronous clear to the chain and selects live or lap-frozen digits for the decoders. It stops the count at 9999 and never wraps.

Parameters:
DIGITS, 4, number of BCD digits handled; data buses are 4*DIGITS bits wide.
SYNC_STAGES, 2, flip-flop synchronizer depth per button (minimum 2).
DEB_CYCLES, 50000, consecutive cycles a synchronized button must be high before it is accepted (minimum 2).
DEB_W, 16, debounce counter width; must satisfy 2^DEB_W > DEB_CYCLES.

Ports:
iClk  in  1  system clock; the only clock.
iRst  in  1  asynchronous, active-low reset.
iStartStop  in  1  raw start/stop button, active-high, asynchronous.
iLap  in  1  raw lap button, active-high, asynchronous.
iClear  in  1  raw clear button, active-high, asynchronous.
iTick  in  1  one-cycle pulse from the frequency divider.
iCount  in  4*DIGITS  live BCD value from the counter chain; digit 0 in bits [3:0].
oTickEn  out  1  gated tick to the units counter count input.
oCntClr  out  1  one-cycle synchronous clear to all counter stages.
oDisp  out  4*DIGITS  digits to the BCD/7-segment decoders.
oState  out  3  current FSM state, for LEDs and debug.
oFull  out  1  high while the count is stopped at all-nines.

Behaviour:
- Reset (iRst=0, asynchronous): state=IDLE; lap register=0; oCntClr=0; oFull=0; debounce counters, levels and synchronizers=0. oDisp follows the live value iCount. oTickEn=0.
- Button path (per button): SYNC_STAGES-flop synchronizer feeds the debounce counter.
  - The counter increments while the synced bit is 1 and the debounced level is 0; it clears to 0 when the synced bit is 0.
  - The level sets when the counter reaches DEB_CYCLES-1 with the synced bit still 1. The level clears on the first synced 0.
  - Event = registered rising edge of the level. Exactly one event per press, with no auto-repeat.
  - A glitch shorter than DEB_CYCLES produces no event.
- Event priority in the same cycle: clear > start/stop > lap. Lower-priority events in that cycle are discarded.
- allNines = every iCount digit equals 4'd9.
- States and encodings: IDLE=0, RUN=1, PAUSE=2, LAP=3, FULL=4.
  - IDLE: start/stop -> RUN. Clear -> IDLE and pulse oCntClr. Lap is ignored.
  - RUN: start/stop -> PAUSE. Lap -> LAP and latch iCount into the lap register on the same edge. Clear -> IDLE and pulse oCntClr. iTick with allNines -> FULL.
  - LAP: lap -> RUN (freeze released). Start/stop -> PAUSE (freeze released). Clear -> IDLE and pulse oCntClr. iTick with allNines -> FULL.
  - PAUSE: start/stop -> RUN. Clear -> IDLE and pulse oCntClr. Lap is ignored.
  - FULL: clear -> IDLE and pulse oCntClr. All other events are ignored.
- oTickEn = iTick AND (state is RUN or LAP) AND NOT allNines. It is combinational from registered state, so a tick reaches the counter with zero latency. The counter therefore reaches 9999 and stops there; 9999->0000 never occurs.
- oCntClr: registered; high for exactly one cycle, on the cycle after the edge on which the clear event is taken.
  - A clear arriving on the same cycle as iTick: the tick is still gated per the current state, and the clear wins on the next cycle.
- oDisp: the lap register in LAP, otherwise iCount.
- oFull: registered; 1 exactly while state=FULL.
- iRst asserted mid-run: immediate return to the reset values. The counter chain shares iRst, so no oCntClr pulse is needed.

Decomposition:
- Package stopwatch_pkg holds:
  - state enum (3-bit, encodings above);
  - BCD_NINE = 4'd9;
  - the default DIGITS.
- One sub-module, btn_conditioner (synchronizer + debounce + edge event), parameterised by SYNC_STAGES, DEB_CYCLES and DEB_W. It is instantiated three times.
- The FSM, tick gate and lap register live in the top module.

Test Plan:
(Bench uses DEB_CYCLES=4, SYNC_STAGES=2, with iTick every 10 cycles.)
- Start press held 20 cycles, from IDLE -> exactly one event; oState=1 on the edge SYNC_STAGES+DEB_CYCLES+1 after the first high sample. oTickEn pulses coincide with iTick.
- 3-cycle glitch on iStartStop -> no event; oState stays 0; oTickEn stays 0.
- RUN with iCount=0123, lap press -> oState=3; oDisp holds 0123 while iCount advances to 0125. A second lap press -> oState=1 and oDisp follows iCount.
- iCount forced to 9999 in RUN, then iTick -> oTickEn=0, oState=4 and oFull=1. Later ticks stay gated. A clear press -> oCntClr high exactly 1 cycle, then oState=0.
- Clear and start/stop events in the same cycle while in PAUSE -> oState=0 and one oCntClr pulse; no transition to RUN.
- iRst dropped to 0 mid-LAP while iTick pulses -> oState=0, oTickEn=0, oDisp=iCount and oCntClr=0, with no clock edge needed. After release, stays IDLE until a press.
